// File: rtl/nibble_serial_subtractor_if.sv
// Handshake bundle for nibble_serial_subtractor.
//   Producer side: in_valid, in_ready, a, b, borrow_in
//   Consumer side: out_valid, out_ready, diff, borrow_out
//   Status:        busy
// The "slave" modport is the subtractor. The "master" modport is the
// producer/consumer environment that drives it.
interface nibble_serial_subtractor_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             borrow_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             busy;

  modport slave (
    input  in_valid,
    input  a,
    input  b,
    input  borrow_in,
    input  out_ready,
    output in_ready,
    output out_valid,
    output diff,
    output borrow_out,
    output busy
  );

  modport master (
    output in_valid,
    output a,
    output b,
    output borrow_in,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  diff,
    input  borrow_out,
    input  busy
  );
endinterface

// File: rtl/nibble_serial_subtractor.sv
// Serial multi-word subtractor. It computes a - b - borrow_in over WIDTH
// bits with a single 4-bit slice. Each clock handles one nibble, starting
// with the LSB nibble, and the borrow is carried between steps in a register.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave modport of nibble_serial_subtractor_if
//           in_valid/in_ready/a/b/borrow_in  operand handshake
//           out_valid/out_ready/diff/borrow_out  result handshake
//           busy  high while an operation is in flight or awaiting pickup
// Latency is WIDTH/4 cycles from accept to out_valid. Every output comes
// either from a flop or from a decode of the state flops.
module nibble_serial_subtractor #(
  parameter int unsigned WIDTH = 16
) (
  input logic                          clk,
  input logic                          rst_n,
  nibble_serial_subtractor_if.slave    bus
);

  localparam int unsigned NIB  = WIDTH / 4;
  localparam int unsigned CW   = $clog2(NIB);
  // Bit offset of the current nibble is {cnt, 2'b00}.
  localparam int unsigned SELW = CW + 2;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              br_q, br_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic [WIDTH-1:0]  diff_q, diff_d;

  logic [SELW-1:0]   nib_sel;
  logic [3:0]        a_nib;
  logic [3:0]        b_nib;
  logic [4:0]        step;

  // The shared 4-bit slice. Bit 4 of the 5-bit result is the borrow out.
  always_comb begin
    nib_sel = {cnt_q, 2'b00};
    a_nib   = a_q[nib_sel +: 4];
    b_nib   = b_q[nib_sel +: 4];
    step    = {1'b0, a_nib} - {1'b0, b_nib} - {4'b0000, br_q};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    a_d     = a_q;
    b_d     = b_q;
    diff_d  = diff_q;

    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          br_d    = bus.borrow_in;
          cnt_d   = '0;
          diff_d  = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        diff_d[nib_sel +: 4] = step[3:0];
        br_d                 = step[4];
        if (cnt_q == CW'(NIB - 1)) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        // diff and br are held until the consumer takes the result.
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      a_q     <= a_d;
      b_q     <= b_d;
      diff_q  <= diff_d;
    end
  end

  // Handshake outputs come straight from the state flops, so they have no
  // combinational path from any input.
  assign bus.in_ready   = (state_q == StIdle);
  assign bus.out_valid  = (state_q == StDone);
  assign bus.busy       = (state_q != StIdle);
  assign bus.diff       = diff_q;
  assign bus.borrow_out = br_q;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Directed bench for nibble_serial_subtractor (WIDTH=16). Expected values are
// computed by hand.
module tb_nibble_serial_subtractor;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   cyc;
  int   acc_cyc;
  int   prev_acc;
  logic [15:0] hold_diff;
  logic        hold_bo;

  nibble_serial_subtractor_if #(.WIDTH(16)) bus ();

  nibble_serial_subtractor #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait for in_ready (bounded), present operands, and return #1 after the
  // accept edge with in_valid dropped.
  task automatic accept(input logic [15:0] av, input logic [15:0] bv, input logic bi,
                        input string tag);
    int n;
    n = 0;
    bus.a         = av;
    bus.b         = bv;
    bus.borrow_in = bi;
    bus.in_valid  = 1'b1;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    acc_cyc = cyc;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a        = 16'hDEAD;
    bus.b        = 16'hBEEF;
  endtask

  // Called #1 after the accept edge. Checks that out_valid is low after E3 and
  // high after E4 with the expected result.
  task automatic expect_result(input logic [15:0] ed, input logic eb, input string tag);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      if (k == 3) check({tag, "_early_valid"}, {31'd0, bus.out_valid}, 32'd0);
    end
    check({tag, "_out_valid"}, {31'd0, bus.out_valid}, 32'd1);
    check({tag, "_diff"}, {16'd0, bus.diff}, {16'd0, ed});
    check({tag, "_borrow"}, {31'd0, bus.borrow_out}, {31'd0, eb});
  endtask

  task automatic release_result(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({tag, "_idle_ready"}, {31'd0, bus.in_ready}, 32'd1);
    check({tag, "_idle_valid"}, {31'd0, bus.out_valid}, 32'd0);
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.borrow_in = 1'b0;
    bus.out_ready = 1'b0;

    // Reset values
    #12;
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_diff", {16'd0, bus.diff}, 32'd0);
    check("rst_borrow", {31'd0, bus.borrow_out}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic subtraction and its latency
    accept(16'h0006, 16'h0003, 1'b0, "basic");
    check("basic_busy", {31'd0, bus.busy}, 32'd1);
    check("basic_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
    expect_result(16'h0003, 1'b0, "basic");
    release_result("basic");

    // Underflow wraps around
    accept(16'h0000, 16'h0001, 1'b0, "wrap");
    expect_result(16'hFFFF, 1'b1, "wrap");
    release_result("wrap");

    // Borrow ripples through all nibbles
    accept(16'h1000, 16'h0001, 1'b0, "ripple");
    expect_result(16'h0FFF, 1'b0, "ripple");
    release_result("ripple");

    accept(16'h000D, 16'h0005, 1'b1, "bin");
    expect_result(16'h0007, 1'b0, "bin");
    release_result("bin");

    // Backpressure: results held while new operands wait
    accept(16'h1234, 16'h0234, 1'b0, "bp");
    expect_result(16'h1000, 1'b0, "bp");
    bus.a         = 16'hAAAA;
    bus.b         = 16'h0001;
    bus.borrow_in = 1'b0;
    bus.in_valid  = 1'b1;
    hold_diff     = bus.diff;
    hold_bo       = bus.borrow_out;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check("bp_hold_diff", {16'd0, bus.diff}, 32'h1000);
      check("bp_hold_borrow", {31'd0, bus.borrow_out}, 32'd0);
      check("bp_in_ready_low", {31'd0, bus.in_ready}, 32'd0);
      check("bp_out_valid_high", {31'd0, bus.out_valid}, 32'd1);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("bp_xfer_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("bp_xfer_out_valid", {31'd0, bus.out_valid}, 32'd0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("bp_next_accept_busy", {31'd0, bus.busy}, 32'd1);
    check("bp_next_accept_in_ready", {31'd0, bus.in_ready}, 32'd0);
    expect_result(16'hAAA9, 1'b0, "bp_next");
    release_result("bp_next");

    // Asynchronous reset while the operation is running
    accept(16'hFFFF, 16'h1234, 1'b0, "rst_mid");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_mid_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_mid_diff", {16'd0, bus.diff}, 32'd0);
    check("rst_mid_borrow", {31'd0, bus.borrow_out}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    accept(16'h00FF, 16'h0F00, 1'b0, "post_rst");
    expect_result(16'hF1FF, 1'b1, "post_rst");
    release_result("post_rst");

    // Back-to-back stream with out_ready held high
    bus.out_ready = 1'b1;
    accept(16'h5678, 16'h1234, 1'b0, "b2b0");
    prev_acc = acc_cyc;
    expect_result(16'h4444, 1'b0, "b2b0");
    accept(16'h0100, 16'h0001, 1'b1, "b2b1");
    check("b2b1_interval", acc_cyc - prev_acc, 32'd6);
    prev_acc = acc_cyc;
    expect_result(16'h00FE, 1'b0, "b2b1");
    accept(16'h8000, 16'h8001, 1'b0, "b2b2");
    check("b2b2_interval", acc_cyc - prev_acc, 32'd6);
    expect_result(16'hFFFF, 1'b1, "b2b2");
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("b2b_end_idle", {31'd0, bus.in_ready}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
